// File: rtl/render_sequencer.sv
// Frame scheduler: one screen clear, then every visible render slot in index
// order is issued to the sprite blitter over valid/ready, waiting on blit_done.
module render_sequencer #(
  parameter int unsigned SLOTS    = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned SCREEN_W = 1280,
  parameter int unsigned SCREEN_H = 300,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  output logic [IDX_W-1:0] slot_idx,
  input  logic [11:0]      slot_sx,
  input  logic [11:0]      slot_sy,
  input  logic [11:0]      slot_w,
  input  logic [11:0]      slot_h,
  input  logic [11:0]      slot_px,
  input  logic [11:0]      slot_py,
  output logic             blit_valid,
  input  logic             blit_ready,
  output logic             blit_clear,
  output logic [11:0]      blit_sx,
  output logic [11:0]      blit_sy,
  output logic [11:0]      blit_w,
  output logic [11:0]      blit_h,
  output logic [11:0]      blit_px,
  output logic [11:0]      blit_py,
  input  logic             blit_done,
  output logic             painter_finished,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOTS - 1);
  localparam logic signed [13:0] LIM_X = 14'(SCREEN_W);
  localparam logic signed [13:0] LIM_Y = 14'(SCREEN_H);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_CWAIT,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             hs;
  logic             cull;
  logic             last_slot;

  logic signed [13:0] px_ext, py_ext, x_end, y_end;

  // Two guard bits: px + w spans -2048..6142, so the end test never wraps.
  assign px_ext = {{2{slot_px[11]}}, slot_px};
  assign py_ext = {{2{slot_py[11]}}, slot_py};
  assign x_end  = px_ext + $signed({2'b00, slot_w});
  assign y_end  = py_ext + $signed({2'b00, slot_h});

  assign cull = (slot_w == '0) || (slot_h == '0) ||
                (px_ext >= LIM_X) || (py_ext >= LIM_Y) ||
                (x_end <= 14'sd0) || (y_end <= 14'sd0);

  assign hs        = blit_valid && blit_ready;
  assign timed_out = (wait_cnt == CNT_LAST);
  assign last_slot = (slot_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (frame_start) state_nx = S_CLEAR;
      S_CLEAR: if (hs) state_nx = S_CWAIT;
      S_CWAIT: if (blit_done || timed_out) state_nx = S_FETCH;
      S_FETCH: state_nx = S_CHECK;
      S_CHECK: state_nx = cull ? S_NEXT : S_ISSUE;
      S_ISSUE: if (hs) state_nx = S_WAIT;
      S_WAIT:  if (blit_done || timed_out) state_nx = S_NEXT;
      S_NEXT:  state_nx = last_slot ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  logic start_frame, clr_idx, inc_idx, load_cmd, accept;
  logic wait_st, tmo_hit, finish, overrun_hit;

  always_comb begin
    start_frame = 1'b0;
    clr_idx     = 1'b0;
    inc_idx     = 1'b0;
    load_cmd    = 1'b0;
    accept      = 1'b0;
    wait_st     = 1'b0;
    tmo_hit     = 1'b0;
    finish      = 1'b0;
    busy        = (state != S_IDLE);
    overrun_hit = frame_start && (state != S_IDLE);
    unique case (state)
      S_IDLE:  start_frame = frame_start;
      S_CLEAR: accept = hs;
      S_CWAIT: begin
        wait_st = 1'b1;
        clr_idx = blit_done || timed_out;
      end
      S_CHECK: load_cmd = !cull;
      S_ISSUE: accept = hs;
      S_WAIT: begin
        wait_st = 1'b1;
        tmo_hit = !blit_done && timed_out;
      end
      S_NEXT:  inc_idx = !last_slot;
      S_DONE:  finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_idx         <= '0;
      blit_valid       <= 1'b0;
      blit_clear       <= 1'b0;
      blit_sx          <= '0;
      blit_sy          <= '0;
      blit_w           <= '0;
      blit_h           <= '0;
      blit_px          <= '0;
      blit_py          <= '0;
      painter_finished <= 1'b0;
      overrun          <= 1'b0;
      timeout_err      <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      if (start_frame) begin
        painter_finished <= 1'b0;
        blit_valid       <= 1'b1;
        blit_clear       <= 1'b1;
      end
      if (load_cmd) begin
        blit_valid <= 1'b1;
        blit_clear <= 1'b0;
        blit_sx    <= slot_sx;
        blit_sy    <= slot_sy;
        blit_w     <= slot_w;
        blit_h     <= slot_h;
        blit_px    <= slot_px;
        blit_py    <= slot_py;
      end
      if (accept)      blit_valid <= 1'b0;
      if (clr_idx)     slot_idx <= '0;
      if (inc_idx)     slot_idx <= slot_idx + IDX_W'(1);
      if (tmo_hit)     timeout_err <= 1'b1;
      if (overrun_hit) overrun <= 1'b1;
      if (finish)      painter_finished <= 1'b1;
      // Counter is held at zero outside the wait states, so each wait starts at 0.
      wait_cnt <= wait_st ? wait_cnt + CNT_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_render_sequencer.sv
// Self-checking bench for render_sequencer: table-driven culling vectors,
// hand-written corner sequences and randomized frames against a slot-list model.
module tb_render_sequencer;
  localparam int SLOTS = 32;
  localparam int SW    = 1280;
  localparam int SH    = 300;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [4:0]  slot_idx;
  logic [11:0] slot_sx = '0, slot_sy = '0, slot_w = '0, slot_h = '0, slot_px = '0, slot_py = '0;
  logic        blit_valid, blit_ready, blit_clear, blit_done;
  logic [11:0] blit_sx, blit_sy, blit_w, blit_h, blit_px, blit_py;
  logic        painter_finished, busy, overrun, timeout_err;

  render_sequencer #(.SLOTS(SLOTS), .IDX_W(5), .SCREEN_W(SW), .SCREEN_H(SH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .slot_idx(slot_idx),
    .slot_sx(slot_sx), .slot_sy(slot_sy), .slot_w(slot_w), .slot_h(slot_h),
    .slot_px(slot_px), .slot_py(slot_py),
    .blit_valid(blit_valid), .blit_ready(blit_ready), .blit_clear(blit_clear),
    .blit_sx(blit_sx), .blit_sy(blit_sy), .blit_w(blit_w), .blit_h(blit_h),
    .blit_px(blit_px), .blit_py(blit_py), .blit_done(blit_done),
    .painter_finished(painter_finished), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          clr;
    int          idx;
    logic [11:0] sx, sy, w, h, px, py;
  } cmd_t;

  typedef struct {
    logic [11:0] w, h, px, py;
    int          draw;
  } cull_vec_t;

  int n_cmp = 0, n_bad = 0;

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input cmd_t c);
    return {47'd0, c.clr, 8'(c.idx), c.sx, c.sy, c.w, c.h, c.px, c.py};
  endfunction

  // Slot store with one cycle of read latency after slot_idx changes.
  logic [11:0] m_sx[SLOTS], m_sy[SLOTS], m_w[SLOTS], m_h[SLOTS], m_px[SLOTS], m_py[SLOTS];

  initial begin
    int idx_d;
    idx_d = 0;
    forever begin
      @(posedge clk);
      #1;
      slot_sx = m_sx[idx_d]; slot_sy = m_sy[idx_d]; slot_w = m_w[idx_d];
      slot_h  = m_h[idx_d];  slot_px = m_px[idx_d]; slot_py = m_py[idx_d];
      idx_d = int'(slot_idx);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < SLOTS; i++) begin
      m_sx[i] = 12'(i * 37 + 5); m_sy[i] = 12'(i * 11 + 3);
      m_w[i] = '0; m_h[i] = '0; m_px[i] = '0; m_py[i] = '0;
    end
  endtask

  task automatic set_slot(input int i, input int w, input int h, input int px, input int py);
    m_w[i] = 12'(w); m_h[i] = 12'(h); m_px[i] = 12'(px); m_py[i] = 12'(py);
  endtask

  function automatic cmd_t mk_cmd(input int i);
    cmd_t c;
    c.clr = 1'b0; c.idx = i;
    c.sx = m_sx[i]; c.sy = m_sy[i]; c.w = m_w[i]; c.h = m_h[i]; c.px = m_px[i]; c.py = m_py[i];
    return c;
  endfunction

  // Reference rule: a slot is drawn when non-empty and overlapping the screen.
  function automatic bit visible(input int i);
    int px, py, w, h;
    px = int'($signed(m_px[i])); py = int'($signed(m_py[i]));
    w  = int'(m_w[i]);           h  = int'(m_h[i]);
    return (w != 0) && (h != 0) && (px < SW) && (py < SH) && (px + w > 0) && (py + h > 0);
  endfunction

  // Blitter model and monitor, all evaluated at the falling edge.
  int   stall_cfg = 0, done_cfg = 0, withhold_idx = -1;
  bit   rand_mode = 0, spur_en = 0, idle_rdy = 0;
  int   cyc = 0, pf_rises = 0, pf_cyc = 0, last_done_cyc = 0, tmo_cyc = -1, wh_acc_cyc = -1;
  int   stable_cnt = 0, stable_bad = 0;
  cmd_t log_q[$];

  initial begin
    bit busy_cmd, withheld, pf_prev, prev_stall;
    int done_left, stall_left;
    logic [72:0] snap;
    cmd_t c;
    busy_cmd = 0; withheld = 0; pf_prev = 0; prev_stall = 0;
    done_left = 0; stall_left = -1; snap = '0;
    blit_ready = 1'b0; blit_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        busy_cmd = 0; withheld = 0; stall_left = -1; prev_stall = 0; pf_prev = 0;
        blit_ready = 1'b0; blit_done = 1'b0;
      end else begin
        if (painter_finished && !pf_prev) begin pf_rises++; pf_cyc = cyc; end
        pf_prev = painter_finished;
        if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
        blit_done = 1'b0;
        if (busy_cmd) begin
          if (done_left == 0) begin
            busy_cmd = 0;
            if (!withheld) begin blit_done = 1'b1; last_done_cyc = cyc; end
          end else done_left--;
        end
        if (prev_stall) begin
          if (blit_valid && {blit_clear, blit_sx, blit_sy, blit_w, blit_h, blit_px, blit_py} == snap)
            stable_cnt++;
          else
            stable_bad++;
        end
        if (blit_valid) begin
          if (stall_left < 0) begin
            stall_left = rand_mode ? int'($urandom_range(0, 4)) : (blit_clear ? 0 : stall_cfg);
            snap = {blit_clear, blit_sx, blit_sy, blit_w, blit_h, blit_px, blit_py};
          end
          blit_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else begin
          blit_ready = idle_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
          stall_left = -1;
        end
        prev_stall = blit_valid && !blit_ready;
        if (blit_valid && blit_ready) begin
          c.clr = blit_clear; c.idx = int'(slot_idx);
          c.sx = blit_sx; c.sy = blit_sy; c.w = blit_w; c.h = blit_h; c.px = blit_px; c.py = blit_py;
          log_q.push_back(c);
          busy_cmd   = 1;
          done_left  = rand_mode ? int'($urandom_range(0, 10)) : done_cfg;
          withheld   = !blit_clear && (int'(slot_idx) == withhold_idx);
          if (withheld) wh_acc_cyc = cyc;
          stall_left = -1;
        end else if (spur_en && !busy_cmd && !blit_done && $urandom_range(0, 7) == 0) begin
          blit_done = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Pulse frame_start, optionally a second time at cycle pulse_at, and wait for painter_finished.
  task automatic run_frame(input int pulse_at, output int lat);
    log_q.delete(); pf_rises = 0; tmo_cyc = -1; wh_acc_cyc = -1;
    lat = -1;
    @(negedge clk);
    frame_start = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      frame_start = (k == pulse_at);
      if (painter_finished) begin lat = k; break; end
    end
    frame_start = 1'b0;
    if (lat < 0) chk_i("frame_completes", 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    cmd_t exp_q[$];
    for (int i = 0; i < SLOTS; i++) if (visible(i)) exp_q.push_back(mk_cmd(i));
    chk_i({tag, "_cmd_count"}, log_q.size(), exp_q.size() + 1);
    if (log_q.size() > 0) chk_i({tag, "_first_is_clear"}, int'(log_q[0].clr), 1);
    for (int j = 0; j < exp_q.size() && j + 1 < log_q.size(); j++)
      chk_v({tag, "_cmd"}, pack(log_q[j + 1]), pack(exp_q[j]));
    chk_i({tag, "_painter_rises"}, pf_rises, 1);
  endtask

  initial begin
    cull_vec_t tbl[14];
    int lat, got;

    tbl[0]  = '{12'd40,   12'd10,   12'(-40),   12'd10,    0};
    tbl[1]  = '{12'd40,   12'd10,   12'd1280,   12'd10,    0};
    tbl[2]  = '{12'd40,   12'd2,    12'd100,    12'd299,   1};
    tbl[3]  = '{12'd0,    12'd10,   12'd10,     12'd10,    0};
    tbl[4]  = '{12'd10,   12'd0,    12'd10,     12'd10,    0};
    tbl[5]  = '{12'd41,   12'd10,   12'(-40),   12'd10,    1};
    tbl[6]  = '{12'd1,    12'd1,    12'd1279,   12'd299,   1};
    tbl[7]  = '{12'd10,   12'd10,   12'd10,     12'd300,   0};
    tbl[8]  = '{12'd10,   12'd10,   12'd10,     12'(-10),  0};
    tbl[9]  = '{12'd10,   12'd11,   12'd10,     12'(-10),  1};
    tbl[10] = '{12'd4095, 12'd4095, 12'd1279,   12'd299,   1};
    tbl[11] = '{12'd4095, 12'd5,    12'(-2048), 12'd0,     1};
    tbl[12] = '{12'd100,  12'd5,    12'd2047,   12'd0,     0};
    tbl[13] = '{12'd4095, 12'd1,    12'(-2048), 12'(-2048), 0};

    clear_mem();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_i("reset_slot_idx", int'(slot_idx), 0);
    chk_i("reset_blit_valid", int'(blit_valid), 0);
    chk_i("reset_blit_clear", int'(blit_clear), 0);
    chk_v("reset_blit_fields", 128'({blit_sx, blit_sy, blit_w, blit_h, blit_px, blit_py}), '0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_overrun", int'(overrun), 0);
    chk_i("reset_timeout_err", int'(timeout_err), 0);
    chk_i("reset_painter_finished", int'(painter_finished), 0);
    rst = 1'b1;

    // Every slot empty, zero-wait blitter.
    run_frame(-1, lat);
    check_frame("empty");
    chk_i("empty_latency", lat, 3 * SLOTS + 4);
    repeat (20) @(negedge clk);
    chk_i("empty_single_rise", pf_rises, 1);
    chk_i("empty_idle_busy", int'(busy), 0);

    // Slots 0, 11, 18 on screen.
    clear_mem();
    set_slot(0, 16, 16, 0, 0);
    set_slot(11, 32, 8, 600, 150);
    set_slot(18, 64, 64, 1200, 250);
    run_frame(-1, lat);
    check_frame("three");
    chk_i("three_count", log_q.size(), 4);
    chk_i("three_pf_after_done", int'(pf_cyc > last_done_cyc), 1);

    // Culling table, one vector in slot 7 per frame.
    for (int v = 0; v < 14; v++) begin
      clear_mem();
      set_slot(7, int'(tbl[v].w), int'(tbl[v].h), int'($signed(tbl[v].px)), int'($signed(tbl[v].py)));
      run_frame(-1, lat);
      chk_i($sformatf("cull_v%0d_draws", v), log_q.size() - 1, tbl[v].draw);
      if (tbl[v].draw == 1 && log_q.size() == 2)
        chk_v($sformatf("cull_v%0d_fields", v), pack(log_q[1]), pack(mk_cmd(7)));
    end

    // Backpressure: ready low for 7 cycles on a draw command.
    clear_mem();
    set_slot(3, 20, 20, 300, 100);
    stall_cfg = 7; stable_cnt = 0;
    run_frame(-1, lat);
    check_frame("stall");
    chk_i("stall_stable_cycles", stable_cnt, 7);
    stall_cfg = 0;

    // Withheld completion on slot 5 must time out after TMO wait cycles.
    do_reset();
    clear_mem();
    set_slot(5, 10, 10, 50, 50);
    set_slot(6, 12, 12, 70, 70);
    withhold_idx = 5;
    run_frame(-1, lat);
    check_frame("timeout");
    chk_i("timeout_err_set", int'(timeout_err), 1);
    chk_i("timeout_wait_cycles", tmo_cyc - wh_acc_cyc, TMO + 1);
    withhold_idx = -1;

    // frame_start coinciding with the DONE->IDLE step counts as overrun.
    do_reset();
    clear_mem();
    run_frame(3 * SLOTS + 3, lat);
    check_frame("done_edge");
    chk_i("done_edge_overrun", int'(overrun), 1);
    chk_i("done_edge_not_restarted", int'(busy), 0);
    chk_i("done_edge_painter", int'(painter_finished), 1);

    // Second frame_start mid-frame, then reset during a stalled ISSUE.
    do_reset();
    clear_mem();
    set_slot(2, 8, 8, 10, 10);
    set_slot(9, 8, 8, 900, 200);
    set_slot(20, 8, 8, -4, -4);
    run_frame(30, lat);
    check_frame("midframe");
    chk_i("midframe_overrun", int'(overrun), 1);
    stall_cfg = 100000;
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (blit_valid && !blit_clear) begin got = 1; break; end
      @(negedge clk);
    end
    chk_i("issue_reached", got, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_i("rst_issue_valid", int'(blit_valid), 0);
    chk_i("rst_issue_busy", int'(busy), 0);
    chk_i("rst_issue_painter", int'(painter_finished), 0);
    chk_i("rst_issue_overrun", int'(overrun), 0);
    chk_i("rst_issue_slot_idx", int'(slot_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stall_cfg = 0;

    // Randomized frames with random stalls, completion delays and stray strobes.
    rand_mode = 1; spur_en = 1; idle_rdy = 1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < SLOTS; i++) begin
        int cat;
        cat = int'($urandom_range(0, 9));
        m_sx[i] = 12'($urandom); m_sy[i] = 12'($urandom);
        m_w[i]  = 12'($urandom_range(1, 200));
        m_h[i]  = 12'($urandom_range(1, 150));
        m_px[i] = 12'(int'($urandom_range(0, 1500)) - 100);
        m_py[i] = 12'(int'($urandom_range(0, 500)) - 100);
        if (cat == 0) m_w[i] = '0;
        if (cat == 1) m_h[i] = '0;
        if (cat == 2) m_px[i] = 12'($urandom);
        if (cat == 3) m_w[i] = 12'($urandom);
      end
      run_frame(-1, lat);
      check_frame($sformatf("rand_f%0d", f));
    end
    chk_i("rand_no_timeout", int'(timeout_err), 0);
    chk_i("rand_no_overrun", int'(overrun), 0);
    chk_i("valid_hold_violations", stable_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
